id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register and operand-select stage that directly feeds the ALU in EX.
- Captures decoded opcode, register operands, immediate and writeback info from decode. Each cycle it presents ALU_In1/ALU_In2/Opcode/Cin plus a per-instruction flag-write mask.
- Supports pipeline freeze (stall), bubble insertion (flush), and optional EX/MEM and MEM/WB operand forwarding.

---
 rtl/id_ex_operand_stage.sv | 174 +++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register and ALU operand-select stage.
// Captures the decoded instruction once per cycle (flush > stall > capture).
// Presents ALU opcode, operands, carry-in and a {Z,N,V} flag-write mask.
// Optional feature macro: ID_EX_OPERAND_FWD_EN enables EX/MEM and MEM/WB
// operand forwarding. When undefined, operands come only from captured data.
module id_ex_operand_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_reg_write,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd_addr,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd_addr,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              ex_valid,
  output logic [3:0]        ALU_Opcode,
  output logic [DATA_W-1:0] ALU_In1,
  output logic [DATA_W-1:0] ALU_In2,
  output logic              ALU_Cin,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic [2:0]        ex_flag_en
);

  // ALU opcode map
  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;

  // Flag-write mask {Z,N,V} per opcode; arithmetic sets all, logic/shift only Z.
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b100;
      OP_RED, OP_PADDSB:              m = 3'b000;
      default:                        m = 3'b000;
    endcase
    return m;
  endfunction

  // Operand source resolution: $0 is always zero, nearest producer wins.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_AW-1:0] r,
    input logic [DATA_W-1:0] cap,
    input logic              em_we,
    input logic [REG_AW-1:0] em_rd,
    input logic [DATA_W-1:0] em_res,
    input logic              mw_we,
    input logic [REG_AW-1:0] mw_rd,
    input logic [DATA_W-1:0] mw_res
  );
    logic [DATA_W-1:0] v;
    v = cap;
`ifdef ID_EX_OPERAND_FWD_EN
    if (mw_we && (mw_rd == r)) v = mw_res;
    if (em_we && (em_rd == r)) v = em_res;
`else
    if (em_we && mw_we && (em_rd == mw_rd) && (em_res == mw_res)) v = cap;
`endif
    if (r == '0) v = '0;
    return v;
  endfunction

  // Captured stage state
  logic              r_valid;
  logic [3:0]        r_opcode;
  logic [REG_AW-1:0] r_rs_addr;
  logic [REG_AW-1:0] r_rt_addr;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic              r_use_imm;
  logic [REG_AW-1:0] r_rd_addr;
  logic              r_reg_write;
  logic              r_cin;
  logic [2:0]        r_flag_en;

  logic              w_bubble;
  logic              w_capture;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;

  // A flush always wins; an invalid decode slot becomes a bubble only when not frozen.
  assign w_bubble  = flush || (!stall && !id_valid);
  assign w_capture = !flush && !stall && id_valid;

  // ---- ID -> EX boundary: stage register with bubble / hold / capture ----
  // Stage register: reset and bubble clear everything, stall holds, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_opcode    <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_rd_addr   <= '0;
      r_reg_write <= 1'b0;
      r_cin       <= 1'b0;
      r_flag_en   <= 3'b000;
    end else if (w_bubble) begin
      r_valid     <= 1'b0;
      r_opcode    <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_rd_addr   <= '0;
      r_reg_write <= 1'b0;
      r_cin       <= 1'b0;
      r_flag_en   <= 3'b000;
    end else if (w_capture) begin
      r_valid     <= 1'b1;
      r_opcode    <= id_opcode;
      r_rs_addr   <= id_rs_addr;
      r_rt_addr   <= id_rt_addr;
      r_rs_data   <= id_rs_data;
      r_rt_data   <= id_rt_data;
      r_imm       <= id_imm;
      r_use_imm   <= id_use_imm;
      r_rd_addr   <= id_rd_addr;
      r_reg_write <= id_reg_write;
      r_cin       <= (id_opcode == OP_SUB);
      r_flag_en   <= flag_mask(id_opcode);
    end
  end

  // ---- EX side: combinational operand select from registered fields ----
  // Resolve both source operands independently (rs == rt is handled naturally).
  always_comb begin
    w_rs_val = fwd(r_rs_addr, r_rs_data,
                   exmem_reg_write, exmem_rd_addr, exmem_result,
                   memwb_reg_write, memwb_rd_addr, memwb_result);
    w_rt_val = fwd(r_rt_addr, r_rt_data,
                   exmem_reg_write, exmem_rd_addr, exmem_result,
                   memwb_reg_write, memwb_rd_addr, memwb_result);
  end

  assign ex_valid     = r_valid;
  assign ALU_Opcode   = r_opcode;
  assign ALU_In1      = w_rs_val;
  assign ALU_In2      = r_use_imm ? r_imm : w_rt_val;
  assign ALU_Cin      = r_cin;
  assign ex_rd_addr   = r_rd_addr;
  assign ex_reg_write = r_reg_write && r_valid;
  assign ex_flag_en   = r_valid ? r_flag_en : 3'b000;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios followed by
// randomized traffic compared against a behavioural model of the stage.
module tb_id_ex_operand_stage;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, flush, id_valid, id_use_imm, id_reg_write;
  logic [3:0]    id_opcode;
  logic [AW-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic          exmem_reg_write, memwb_reg_write;
  logic [AW-1:0] exmem_rd_addr, memwb_rd_addr;
  logic [DW-1:0] exmem_result, memwb_result;
  logic          ex_valid, ALU_Cin, ex_reg_write;
  logic [3:0]    ALU_Opcode;
  logic [DW-1:0] ALU_In1, ALU_In2;
  logic [AW-1:0] ex_rd_addr;
  logic [2:0]    ex_flag_en;

  id_ex_operand_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr),
    .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr),
    .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ALU_Opcode(ALU_Opcode),
    .ALU_In1(ALU_In1), .ALU_In2(ALU_In2), .ALU_Cin(ALU_Cin),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_flag_en(ex_flag_en)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model of the instruction currently held in EX
  logic          m_valid, m_use_imm, m_rw;
  logic [3:0]    m_op;
  logic [AW-1:0] m_rs, m_rt, m_rd;
  logic [DW-1:0] m_rsd, m_rtd, m_imm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_flags(input logic [3:0] op);
    if (op == 4'd0 || op == 4'd1) return 3'b111;
    if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [DW-1:0] exp_fwd(input logic [AW-1:0] r, input logic [DW-1:0] cap);
    if (r == 0) return '0;
`ifdef ID_EX_OPERAND_FWD_EN
    if (exmem_reg_write && exmem_rd_addr == r) return exmem_result;
    if (memwb_reg_write && memwb_rd_addr == r) return memwb_result;
`endif
    return cap;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_use_imm = 0; m_rw = 0; m_op = 0;
    m_rs = 0; m_rt = 0; m_rd = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
  endtask

  // Advance one clock edge, updating the model from the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_clear();
    else if (flush) model_clear();
    else if (stall) begin end
    else if (!id_valid) model_clear();
    else begin
      m_valid = 1; m_op = id_opcode; m_rs = id_rs_addr; m_rt = id_rt_addr;
      m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
      m_use_imm = id_use_imm; m_rd = id_rd_addr; m_rw = id_reg_write;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, ".op"},    32'(ALU_Opcode), 32'(m_op));
    chk({tag, ".in1"},   32'(ALU_In1), 32'(exp_fwd(m_rs, m_rsd)));
    chk({tag, ".in2"},   32'(ALU_In2), 32'(m_use_imm ? m_imm : exp_fwd(m_rt, m_rtd)));
    chk({tag, ".cin"},   32'(ALU_Cin), 32'(m_valid && m_op == 4'd1));
    chk({tag, ".rd"},    32'(ex_rd_addr), 32'(m_rd));
    chk({tag, ".rw"},    32'(ex_reg_write), 32'(m_rw && m_valid));
    chk({tag, ".flag"},  32'(ex_flag_en), 32'(m_valid ? exp_flags(m_op) : 3'b000));
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                           input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                           input logic ui, input logic [DW-1:0] imm, input logic [AW-1:0] rd);
    id_valid = 1; id_opcode = op; id_rs_addr = rs; id_rt_addr = rt;
    id_rs_data = rsd; id_rt_data = rtd; id_use_imm = ui; id_imm = imm;
    id_rd_addr = rd; id_reg_write = 1;
  endtask

  logic [DW-1:0] exp_hz;

  initial begin
    rst_n = 0; stall = 0; flush = 0;
    set_instr(4'd0, 0, 0, 0, 0, 0, 0, 0); id_valid = 0; id_reg_write = 0;
    exmem_reg_write = 0; exmem_rd_addr = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd_addr = 0; memwb_result = 0;
    model_clear();
    #2;
    check_model("reset");
    tick(); tick();
    rst_n = 1;

    // ADD r1,r2 then asynchronous reset between edges
    set_instr(4'd0, 4'd1, 4'd2, 16'd5, 16'd3, 0, 0, 4'd4);
    tick();
    chk("add.in1", 32'(ALU_In1), 32'h5);
    chk("add.in2", 32'(ALU_In2), 32'h3);
    #2 rst_n = 0; model_clear();
    #1;
    chk("rst.in1", 32'(ALU_In1), 32'h0);
    chk("rst.valid", 32'(ex_valid), 32'h0);
    check_model("rst");
    @(negedge clk); rst_n = 1;
    tick();
    chk("rel.in1", 32'(ALU_In1), 32'h5);
    chk("rel.valid", 32'(ex_valid), 32'h1);

    // SUB: carry-in and full flag mask
    set_instr(4'd1, 4'd6, 4'd7, 16'h0010, 16'h0001, 0, 0, 4'd8);
    tick();
    chk("sub.cin", 32'(ALU_Cin), 32'h1);
    chk("sub.flag", 32'(ex_flag_en), 32'h7);
    chk("sub.in1", 32'(ALU_In1), 32'h0010);
    chk("sub.in2", 32'(ALU_In2), 32'h0001);

    // Double hazard on r3
    set_instr(4'd0, 4'd3, 4'd9, 16'h1234, 16'h0042, 0, 0, 4'd5);
    exmem_reg_write = 1; exmem_rd_addr = 4'd3; exmem_result = 16'hAAAA;
    memwb_reg_write = 1; memwb_rd_addr = 4'd3; memwb_result = 16'h5555;
    tick();
`ifdef ID_EX_OPERAND_FWD_EN
    exp_hz = 16'hAAAA;
`else
    exp_hz = 16'h1234;
`endif
    chk("hz.both", 32'(ALU_In1), 32'(exp_hz));
    chk("hz.rt", 32'(ALU_In2), 32'h0042);
    exmem_reg_write = 0;
    #1;
`ifdef ID_EX_OPERAND_FWD_EN
    exp_hz = 16'h5555;
`else
    exp_hz = 16'h1234;
`endif
    chk("hz.memwb", 32'(ALU_In1), 32'(exp_hz));
    memwb_reg_write = 0;

    // $0 source with a producer writing r0, plus immediate operand
    set_instr(4'd0, 4'd0, 4'd3, 16'hBEEF, 16'h1111, 1, 16'h0007, 4'd2);
    exmem_reg_write = 1; exmem_rd_addr = 4'd0; exmem_result = 16'hFFFF;
    tick();
    chk("r0.in1", 32'(ALU_In1), 32'h0);
    chk("imm.in2", 32'(ALU_In2), 32'h0007);
    exmem_reg_write = 0;

    // XOR then 3 stalled cycles with changing decode inputs
    set_instr(4'd2, 4'd10, 4'd11, 16'h0F0F, 16'h00FF, 0, 0, 4'd12);
    tick();
    chk("xor.flag", 32'(ex_flag_en), 32'h4);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_instr(4'(i + 4), 4'(i + 1), 4'(i + 2), 16'($urandom), 16'($urandom), 0, 0, 4'd1);
      tick();
      chk("stall.in1", 32'(ALU_In1), 32'h0F0F);
      chk("stall.op", 32'(ALU_Opcode), 32'h2);
      check_model("stall");
    end
    flush = 1;
    tick();
    chk("flush.valid", 32'(ex_valid), 32'h0);
    chk("flush.rw", 32'(ex_reg_write), 32'h0);
    chk("flush.flag", 32'(ex_flag_en), 32'h0);
    stall = 0; flush = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      id_valid = ($urandom_range(0, 7) != 0);
      id_opcode = 4'($urandom);
      id_rs_addr = 4'($urandom_range(0, 5));
      id_rt_addr = 4'($urandom_range(0, 5));
      id_rs_data = 16'($urandom);
      id_rt_data = 16'($urandom);
      id_imm = 16'($urandom);
      id_use_imm = 1'($urandom);
      id_rd_addr = 4'($urandom);
      id_reg_write = 1'($urandom);
      tick();
      exmem_reg_write = 1'($urandom);
      exmem_rd_addr = 4'($urandom_range(0, 5));
      exmem_result = 16'($urandom);
      memwb_reg_write = 1'($urandom);
      memwb_rd_addr = 4'($urandom_range(0, 5));
      memwb_result = 16'($urandom);
      #1;
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
